pair_assembler: RTL and testbench

Serial-to-parallel counterpart of the byte splitter. Accepts a stream of 2-bit chunks over a valid/ready handshake and reassembles every 4 chunks into one 8-bit word. Also produces the arithmetic sum of the four chunks. The result is held in a single-entry output register with its own valid/ready handshake. Sits downstream of any 2-bit serial link and feeds byte-wide consumers.

---
 rtl/pair_assembler.sv | 152 +++++++++++++++
 tb/tb_pair_assembler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pair_assembler.sv
// Reassembles CHUNKS serial chunks, MSB-first, into one word plus the sum of its chunks.
// Define PAIR_ASSEMBLER_ERRCNT_EN to add a saturating err_count output that counts sync_err pulses.
module pair_assembler #(
    parameter  int CHUNK_W = 2,
    parameter  int CHUNKS  = 4,
    localparam int WORD_W  = CHUNK_W * CHUNKS,
    localparam int SUM_W   = CHUNK_W + $clog2(CHUNKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHUNK_W-1:0] chunk_in,
    input  logic               chunk_sof,
    input  logic               chunk_valid,
    output logic               chunk_ready,
    output logic [WORD_W-1:0]  word_out,
    output logic [SUM_W-1:0]   word_sum,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               sync_err
`ifdef PAIR_ASSEMBLER_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    localparam int CNT_W  = $clog2(CHUNKS);
    localparam int PART_W = WORD_W - CHUNK_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PART_W-1:0]  partial_q, partial_d;
    logic [WORD_W-1:0]  word_out_q, word_out_d;
    logic [SUM_W-1:0]   word_sum_q, word_sum_d;
    logic               word_valid_q, word_valid_d;
    logic               sync_err_q, sync_err_d;

    logic               chunk_accept;
    logic [WORD_W-1:0]  full_word;
    logic [SUM_W-1:0]   full_sum;

    // Only the closing chunk needs a free output slot, so earlier chunks never stall.
    assign chunk_ready  = !(count_q == LAST && word_valid_q && !word_ready);
    assign chunk_accept = chunk_valid && chunk_ready;
    assign full_word    = {partial_q, chunk_in};

    always_comb begin
        full_sum = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            full_sum = full_sum + SUM_W'(full_word[i*CHUNK_W +: CHUNK_W]);
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        partial_d    = partial_q;
        word_out_d   = word_out_q;
        word_sum_d   = word_sum_q;
        word_valid_d = word_valid_q;
        sync_err_d   = 1'b0;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (chunk_accept) begin
            case (state_q)
                IDLE: begin
                    partial_d = PART_W'(chunk_in);
                    count_d   = CNT_W'(1);
                    state_d   = COLLECT;
                end
                COLLECT: begin
                    if (chunk_sof) begin
                        // A new word started early: drop the partial one and restart at position 0.
                        partial_d  = PART_W'(chunk_in);
                        count_d    = CNT_W'(1);
                        sync_err_d = 1'b1;
                    end else if (count_q == LAST) begin
                        word_out_d   = full_word;
                        word_sum_d   = full_sum;
                        word_valid_d = 1'b1;
                        partial_d    = '0;
                        count_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        partial_d = full_word[PART_W-1:0];
                        count_d   = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    partial_d = '0;
                    count_d   = '0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            partial_q    <= '0;
            word_out_q   <= '0;
            word_sum_q   <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            partial_q    <= partial_d;
            word_out_q   <= word_out_d;
            word_sum_q   <= word_sum_d;
            word_valid_q <= word_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_sum   = word_sum_q;
    assign word_valid = word_valid_q;
    assign sync_err   = sync_err_q;

`ifdef PAIR_ASSEMBLER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sync_err_d && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_pair_assembler.sv
// Directed testbench for pair_assembler; err_count steps are compiled in with PAIR_ASSEMBLER_ERRCNT_EN.
module tb_pair_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] chunk_in;
    logic       chunk_sof;
    logic       chunk_valid;
    logic       chunk_ready;
    logic [7:0] word_out;
    logic [3:0] word_sum;
    logic       word_valid;
    logic       word_ready;
    logic       sync_err;
`ifdef PAIR_ASSEMBLER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;

    pair_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .chunk_in    (chunk_in),
        .chunk_sof   (chunk_sof),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .word_out    (word_out),
        .word_sum    (word_sum),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sync_err    (sync_err)
`ifdef PAIR_ASSEMBLER_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called and returns one time unit after a rising edge; holds the chunk until it is accepted.
    task automatic apply_stimulus(input logic [1:0] data, input logic sof, input string tag);
        int waited = 0;
        chunk_in    = data;
        chunk_sof   = sof;
        chunk_valid = 1'b1;
        while (!chunk_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!chunk_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_accept observed=stalled expected=accepted", tag);
        end else begin
            @(posedge clk);
            #1;
        end
        chunk_valid = 1'b0;
        chunk_sof   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        chunk_in    = 2'b00;
        chunk_sof   = 1'b0;
        chunk_valid = 1'b0;
        word_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_word_out", word_out, 8'h00);
        check_output("reset_word_sum", word_sum, 4'd0);
        check_output("reset_word_valid", word_valid, 1'b0);
        check_output("reset_sync_err", sync_err, 1'b0);
        check_output("reset_chunk_ready", chunk_ready, 1'b1);
        rst = 1'b0;

        $display("[TB] basic word");
        apply_stimulus(2'b00, 1'b1, "basic0");
        apply_stimulus(2'b11, 1'b0, "basic1");
        apply_stimulus(2'b01, 1'b0, "basic2");
        check_output("basic_not_yet_valid", word_valid, 1'b0);
        apply_stimulus(2'b01, 1'b0, "basic3");
        check_output("basic_valid", word_valid, 1'b1);
        check_output("basic_word", word_out, 8'h35);
        check_output("basic_sum", word_sum, 4'd5);
        check_output("basic_sync_err", sync_err, 1'b0);
        @(posedge clk);
        #1;
        check_output("basic_valid_cleared", word_valid, 1'b0);

        $display("[TB] back-to-back words");
        apply_stimulus(2'b11, 1'b1, "b2b0");
        apply_stimulus(2'b11, 1'b0, "b2b1");
        apply_stimulus(2'b11, 1'b0, "b2b2");
        apply_stimulus(2'b11, 1'b0, "b2b3");
        check_output("b2b_word_a", word_out, 8'hFF);
        check_output("b2b_sum_a", word_sum, 4'd12);
        check_output("b2b_ready_a", chunk_ready, 1'b1);
        apply_stimulus(2'b00, 1'b1, "b2b4");
        apply_stimulus(2'b00, 1'b0, "b2b5");
        apply_stimulus(2'b00, 1'b0, "b2b6");
        check_output("b2b_ready_mid", chunk_ready, 1'b1);
        apply_stimulus(2'b01, 1'b0, "b2b7");
        check_output("b2b_valid_b", word_valid, 1'b1);
        check_output("b2b_word_b", word_out, 8'h01);
        check_output("b2b_sum_b", word_sum, 4'd1);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        word_ready = 1'b0;
        apply_stimulus(2'b10, 1'b1, "bp0");
        apply_stimulus(2'b10, 1'b0, "bp1");
        apply_stimulus(2'b01, 1'b0, "bp2");
        apply_stimulus(2'b01, 1'b0, "bp3");
        check_output("bp_word_a", word_out, 8'hA5);
        apply_stimulus(2'b01, 1'b1, "bp4");
        apply_stimulus(2'b10, 1'b0, "bp5");
        apply_stimulus(2'b11, 1'b0, "bp6");
        check_output("bp_stall_ready", chunk_ready, 1'b0);
        chunk_in    = 2'b00;
        chunk_sof   = 1'b0;
        chunk_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("bp_held_word", word_out, 8'hA5);
        check_output("bp_held_sum", word_sum, 4'd6);
        check_output("bp_held_valid", word_valid, 1'b1);
        check_output("bp_still_stalled", chunk_ready, 1'b0);
        word_ready = 1'b1;
        #1;
        check_output("bp_release_ready", chunk_ready, 1'b1);
        @(posedge clk);
        #1;
        chunk_valid = 1'b0;
        check_output("bp_valid_b", word_valid, 1'b1);
        check_output("bp_word_b", word_out, 8'h6C);
        check_output("bp_sum_b", word_sum, 4'd6);
        @(posedge clk);
        #1;
        check_output("bp_valid_cleared", word_valid, 1'b0);

        $display("[TB] resync");
        apply_stimulus(2'b11, 1'b1, "rs0");
        apply_stimulus(2'b01, 1'b0, "rs1");
        check_output("rs_no_err_yet", sync_err, 1'b0);
        apply_stimulus(2'b10, 1'b1, "rs2");
        check_output("rs_sync_err", sync_err, 1'b1);
        apply_stimulus(2'b01, 1'b0, "rs3");
        check_output("rs_sync_err_pulse", sync_err, 1'b0);
        apply_stimulus(2'b00, 1'b0, "rs4");
        apply_stimulus(2'b11, 1'b0, "rs5");
        check_output("rs_valid", word_valid, 1'b1);
        check_output("rs_word", word_out, 8'h93);
        check_output("rs_sum", word_sum, 4'd6);
`ifdef PAIR_ASSEMBLER_ERRCNT_EN
        check_output("rs_err_count", err_count, 8'd1);
`endif

        $display("[TB] reset mid-word");
        apply_stimulus(2'b11, 1'b1, "rst0");
        apply_stimulus(2'b10, 1'b0, "rst1");
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_word_out", word_out, 8'h00);
        check_output("rst_word_sum", word_sum, 4'd0);
        check_output("rst_word_valid", word_valid, 1'b0);
        check_output("rst_chunk_ready", chunk_ready, 1'b1);
`ifdef PAIR_ASSEMBLER_ERRCNT_EN
        check_output("rst_err_count", err_count, 8'd0);
`endif
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(2'b01, 1'b1, "post0");
        apply_stimulus(2'b01, 1'b0, "post1");
        apply_stimulus(2'b01, 1'b0, "post2");
        apply_stimulus(2'b01, 1'b0, "post3");
        check_output("post_valid", word_valid, 1'b1);
        check_output("post_word", word_out, 8'h55);
        check_output("post_sum", word_sum, 4'd4);
        check_output("post_sync_err", sync_err, 1'b0);

`ifdef PAIR_ASSEMBLER_ERRCNT_EN
        $display("[TB] error counter saturation");
        apply_stimulus(2'b01, 1'b1, "sat_first");
        for (int i = 0; i < 260; i++) begin
            apply_stimulus(2'b01, 1'b1, "sat_resync");
        end
        check_output("sat_err_count", err_count, 8'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
